elim_sched: RTL and testbench

Round-robin scheduler that shares a single Gaussian-elimination core (an `elim` instance) between R requesting clients. It grants one job at a time, pulses the core's start, and waits for the core's done. A watchdog aborts hung jobs. Each job finishes with a per-requester acknowledge, an error flag and the measured cycle count. It sits between the host-side job queues and the `elim` core.

---
 rtl/elim_sched_pkg.sv | 17 +
 rtl/elim_sched_if.sv | 30 +++
 rtl/elim_sched_rr_pick.sv | 38 +++
 rtl/elim_sched.sv | 120 ++++++++++++
 tb/tb_elim_sched.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/elim_sched_pkg.sv
// Shared types and helpers for the elim_sched round-robin job scheduler.
package elim_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_ABORT  = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  // Width of a client index; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elim_sched_if.sv
// Host/core-facing signal bundle of elim_sched; slave is the scheduler side.
interface elim_sched_if #(
  parameter int unsigned R  = 4,
  parameter int unsigned CW = 16
) ();
  import elim_sched_pkg::*;

  localparam int unsigned IW = id_width(R);

  logic [R-1:0]  req;
  logic [R-1:0]  ack;
  logic          err;
  logic [CW-1:0] cycles;
  logic          busy;
  logic [IW-1:0] cur_id;
  logic          core_start;
  logic          core_rst;
  logic          core_done;

  modport master (
    output req, core_done,
    input  ack, err, cycles, busy, cur_id, core_start, core_rst
  );

  modport slave (
    input  req, core_done,
    output ack, err, cycles, busy, cur_id, core_start, core_rst
  );

endinterface

// File: rtl/elim_sched_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at R.
module rr_pick
  import elim_sched_pkg::*;
#(
  parameter int unsigned R = 4,
  localparam int unsigned IW = id_width(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_id,
  output logic          any
);

  logic [2*R-1:0] dbl;
  logic [R-1:0]   rot;
  logic [IW:0]    off;
  logic [IW:0]    sum;

  always_comb begin
    dbl = {req, req};
    rot = R'(dbl >> ptr);
    off = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < R; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        off = (IW+1)'(i);
      end
    end
    // ptr + off can reach 2R-2; fold back into 0..R-1 without relying on 2^IW wrap.
    sum = {1'b0, ptr} + off;
    if (sum >= (IW+1)'(R)) begin
      sum = sum - (IW+1)'(R);
    end
    grant_id = sum[IW-1:0];
  end

endmodule

// File: rtl/elim_sched.sv
// Shares one elimination core between R clients: round-robin grant, start pulse,
// watchdog abort, and a per-client ack carrying error flag and RUN-cycle count.
module elim_sched
  import elim_sched_pkg::*;
#(
  parameter int unsigned R       = 4,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CW      = 16
) (
  input logic         clk,
  input logic         rst,
  elim_sched_if.slave bus
);

  localparam int unsigned IW = id_width(R);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cur_id_q, cur_id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          err_q, err_d;
  logic [R-1:0]  ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          start_q, start_d;
  logic          crst_q, crst_d;

  logic [IW-1:0] grant_id;
  logic          any;

  rr_pick #(.R(R)) u_pick (
    .req      (bus.req),
    .ptr      (ptr_q),
    .grant_id (grant_id),
    .any      (any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_id_d = cur_id_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d  = ST_LAUNCH;
          cur_id_d = grant_id;
          ptr_d    = (grant_id == IW'(R - 1)) ? '0 : grant_id + IW'(1);
        end
      end
      ST_LAUNCH: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        // A done arriving on the final permitted cycle still counts as success.
        if (bus.core_done) begin
          state_d  = ST_REPORT;
          cycles_d = cnt_q + CW'(1);
          err_d    = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = ST_ABORT;
          cycles_d = CW'(TIMEOUT);
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ABORT:  state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Output pulses are decoded from the next state so they appear registered.
    busy_d  = (state_d != ST_IDLE);
    start_d = (state_d == ST_LAUNCH);
    crst_d  = (state_d == ST_ABORT);
    for (int unsigned i = 0; i < R; i++) begin
      ack_d[i] = (state_d == ST_REPORT) && (cur_id_d == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cur_id_q <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      err_q    <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      crst_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cur_id_q <= cur_id_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      crst_q   <= crst_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
  assign bus.cycles     = cycles_q;
  assign bus.busy       = busy_q;
  assign bus.cur_id     = cur_id_q;
  assign bus.core_start = start_q;
  assign bus.core_rst   = crst_q;

endmodule

// File: tb/tb_elim_sched.sv
// Directed plus randomized bench for elim_sched with R=3 (non-power-of-two) and TIMEOUT=8.
module tb_elim_sched;

  localparam int unsigned R       = 3;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CW      = 4;

  logic clk;
  logic rst;

  elim_sched_if #(.R(R), .CW(CW)) bus ();

  elim_sched #(.R(R), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int mptr = 0;
  int last_id = 0;
  int last_cycles = 0;
  int last_err = 0;
  int acks [R];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: scan ids starting at the model pointer, modulo R.
  function automatic int model_pick(input logic [R-1:0] rq);
    for (int k = 0; k < R; k++) begin
      if (rq[(mptr + k) % R]) return (mptr + k) % R;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},    bus.ack, 0);
    check({tag, "_err"},    bus.err, 0);
    check({tag, "_cycles"}, bus.cycles, 0);
    check({tag, "_busy"},   bus.busy, 0);
    check({tag, "_cur_id"}, bus.cur_id, 0);
    check({tag, "_start"},  bus.core_start, 0);
    check({tag, "_crst"},   bus.core_rst, 0);
  endtask

  // Called at a negedge with the DUT idle. lat = RUN cycle on which done is driven
  // (> TIMEOUT means never); rst_at = RUN cycle on which reset is pulsed (0 = none).
  task automatic do_job(input logic [R-1:0] rq, input int lat, input int rst_at,
                        input bit spur, input logic [R-1:0] rq_mid);
    int exp_id;
    bit done_seen;
    logic [R-1:0] ea;
    exp_id = model_pick(rq);
    mptr = (exp_id + 1) % R;
    bus.req = rq;
    @(negedge clk);
    check("launch_start", bus.core_start, 1);
    check("launch_busy", bus.busy, 1);
    check("launch_id", bus.cur_id, exp_id);
    check("launch_ack", bus.ack, 0);
    bus.req = rq_mid;
    bus.core_done = spur;
    done_seen = 0;
    for (int n = 1; n <= TIMEOUT; n++) begin
      @(negedge clk);
      bus.core_done = 1'b0;
      check("run_busy", bus.busy, 1);
      check("run_start", bus.core_start, 0);
      check("run_ack", bus.ack, 0);
      check("run_crst", bus.core_rst, 0);
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        mptr = 0;
        last_cycles = 0;
        last_err = 0;
        return;
      end
      if (n == lat) begin
        bus.core_done = 1'b1;
        done_seen = 1;
        break;
      end
    end
    @(negedge clk);
    bus.core_done = 1'b0;
    if (!done_seen) begin
      check("abort_crst", bus.core_rst, 1);
      check("abort_ack", bus.ack, 0);
      check("abort_busy", bus.busy, 1);
      @(negedge clk);
    end
    ea = '0;
    ea[exp_id] = 1'b1;
    last_cycles = done_seen ? lat : TIMEOUT;
    last_err = done_seen ? 0 : 1;
    check("rep_ack", bus.ack, ea);
    check("rep_err", bus.err, last_err);
    check("rep_cycles", bus.cycles, last_cycles);
    check("rep_crst", bus.core_rst, 0);
    check("rep_busy", bus.busy, 1);
    check("rep_id", bus.cur_id, exp_id);
    acks[exp_id]++;
    last_id = exp_id;
    bus.req = '0;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_ack", bus.ack, 0);
    check("idle_err_hold", bus.err, last_err);
    check("idle_cycles_hold", bus.cycles, last_cycles);
    check("idle_id_hold", bus.cur_id, exp_id);
  endtask

  initial begin
    logic [R-1:0] pend;
    int gap;
    for (int i = 0; i < R; i++) acks[i] = 0;
    rst = 1'b1;
    bus.req = '1;
    bus.core_done = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    bus.req = '0;
    bus.core_done = 1'b0;
    @(negedge clk);
    check("post_reset_busy", bus.busy, 0);

    // Single job, then wrap from id 2 back to 0 and on to 1.
    do_job(3'b010, 7, 0, 0, 3'b010);
    do_job(3'b100, 3, 0, 0, 3'b100);
    do_job(3'b011, 1, 0, 0, 3'b011);
    do_job(3'b011, 5, 0, 0, 3'b000);

    // Fairness: all requesting continuously.
    for (int i = 0; i < R; i++) acks[i] = 0;
    for (int j = 0; j < 2 * R; j++) do_job(3'b111, 2 + j, 0, 0, 3'b111);
    for (int i = 0; i < R; i++) check("fair_acks", acks[i], 2);

    // Watchdog, recovery, then done/timeout collision.
    do_job(3'b001, TIMEOUT + 1, 0, 0, 3'b001);
    do_job(3'b001, 4, 0, 0, 3'b001);
    do_job(3'b010, TIMEOUT, 0, 0, 3'b010);

    // Stray done while idle changes nothing.
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stray_busy", bus.busy, 0);
      check("stray_ack", bus.ack, 0);
      check("stray_start", bus.core_start, 0);
      check("stray_cycles", bus.cycles, last_cycles);
      check("stray_err", bus.err, last_err);
    end

    // Reset in RUN with cnt=5; pointer must return to 0.
    do_job(3'b001, TIMEOUT + 1, 6, 0, 3'b101);
    do_job(3'b101, 3, 0, 0, 3'b101);
    do_job(3'b100, 2, 0, 0, 3'b100);

    // Randomized traffic.
    pend = '0;
    for (int j = 0; j < 30; j++) begin
      pend = pend | R'($urandom_range(0, (1 << R) - 1));
      if (pend == '0) pend[$urandom_range(0, R - 1)] = 1'b1;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.req = '0;
        @(negedge clk);
        check("gap_busy", bus.busy, 0);
      end
      do_job(pend, $urandom_range(1, TIMEOUT + 2), 0, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) != 0) ? pend : R'($urandom));
      pend[last_id] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
